mult_addsub_accumulator_pipe: RTL and testbench

//  Parametrised, pipelined multiply-accumulate unit: z_out <= z_out +/- a*b, or load +/-a*b, selected per beat.

---
 rtl/mult_addsub_accumulator_pipe.sv | 135 +++++++++++++
 tb/tb_mult_addsub_accumulator_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_addsub_accumulator_pipe.sv
// rtl/mult_addsub_accumulator_pipe.sv - pipelined multiply add/sub/load accumulator with sticky overflow
// Optional SATURATE_EN macro clamps z_out on overflow instead of wrapping.
module mult_addsub_accumulator_pipe #(
  parameter int A_W       = 20,
  parameter int B_W       = 18,
  parameter int ACC_W     = A_W + B_W,
  parameter int SIGNED    = 0,
  parameter int MULT_PIPE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic             clear,
  output logic [ACC_W-1:0] z_out,
  output logic             out_valid,
  output logic             overflow
);

  localparam int P_W = A_W + B_W;
  localparam int X_W = ACC_W + 2;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  logic [A_W-1:0] a_r;
  logic [B_W-1:0] b_r;
  logic [1:0]     op_r;
  logic           v_r;

  always_ff @(posedge clk) begin
    a_r  <= a;
    b_r  <= b;
    op_r <= op;
    if (reset) v_r <= 1'b0;
    else       v_r <= in_valid;
  end

  // Operands are widened to the full product width first so that the low
  // P_W bits of the multiply are the exact product in either signedness.
  logic [P_W-1:0] a_x, b_x, prod;
  assign a_x  = (SIGNED != 0) ? {{B_W{a_r[A_W-1]}}, a_r} : {{B_W{1'b0}}, a_r};
  assign b_x  = (SIGNED != 0) ? {{A_W{b_r[B_W-1]}}, b_r} : {{A_W{1'b0}}, b_r};
  assign prod = a_x * b_x;

  logic [P_W-1:0]   p_q  [MULT_PIPE+1];
  logic [1:0]       op_q [MULT_PIPE+1];
  logic [MULT_PIPE:0] v_q;

  always_ff @(posedge clk) begin
    p_q[0]  <= prod;
    op_q[0] <= op_r;
    for (int i = 1; i <= MULT_PIPE; i++) begin
      p_q[i]  <= p_q[i-1];
      op_q[i] <= op_q[i-1];
    end
    if (reset) begin
      v_q <= '0;
    end else begin
      v_q[0] <= v_r;
      for (int i = 1; i <= MULT_PIPE; i++) v_q[i] <= v_q[i-1];
    end
  end

  logic [P_W-1:0]   p_fin;
  logic [1:0]       op_fin;
  logic             v_fin;
  logic [X_W-1:0]   p_e, z_e, res;
  logic [ACC_W-1:0] z_base, z_new;
  logic             ov_base, ovf;

  assign p_fin  = p_q[MULT_PIPE];
  assign op_fin = op_q[MULT_PIPE];
  assign v_fin  = v_q[MULT_PIPE];

  // clear takes effect before a coinciding beat is applied.
  assign z_base  = clear ? '0 : z_out;
  assign ov_base = clear ? 1'b0 : overflow;

  assign p_e = (SIGNED != 0) ? {{(X_W-P_W){p_fin[P_W-1]}}, p_fin}
                             : {{(X_W-P_W){1'b0}}, p_fin};
  assign z_e = (SIGNED != 0) ? {{2{z_base[ACC_W-1]}}, z_base}
                             : {2'b00, z_base};

  always_comb begin
    res = '0;
    case (op_fin)
      OP_ADD:  res = z_e + p_e;
      OP_SUB:  res = z_e - p_e;
      OP_LOAD: res = p_e;
      default: res = '0 - p_e;
    endcase
  end

  // Two guard bits hold the exact result; out of range when they disagree
  // with the representable span.
  assign ovf = (SIGNED != 0)
             ? !((&res[X_W-1:ACC_W-1]) || !(|res[X_W-1:ACC_W-1]))
             : (|res[X_W-1:ACC_W]);

`ifdef SATURATE_EN
  always_comb begin
    z_new = res[ACC_W-1:0];
    if (ovf) begin
      if (SIGNED != 0)
        z_new = res[X_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        z_new = res[X_W-1] ? '0 : '1;
    end
  end
`else
  assign z_new = res[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      z_out     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= v_fin;
      if (v_fin) begin
        z_out    <= z_new;
        overflow <= ov_base | ovf;
      end else if (clear) begin
        z_out    <= '0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_addsub_accumulator_pipe.sv
// tb/tb_mult_addsub_accumulator_pipe.sv - self-checking bench, unsigned and signed instances against a behavioural model
module tb_mult_addsub_accumulator_pipe;

  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, LOAD = 2'd2, LNEG = 2'd3;
`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] a = '0;
  logic [17:0] b = '0;
  logic        in_valid = 1'b0;
  logic [1:0]  op = '0;
  logic        clear = 1'b0;
  logic [37:0] z_u, z_s;
  logic        v_u, v_s, o_u, o_s;

  always #5 clk = ~clk;

  mult_addsub_accumulator_pipe #(.SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid), .op(op),
    .clear(clear), .z_out(z_u), .out_valid(v_u), .overflow(o_u));

  mult_addsub_accumulator_pipe #(.SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .a(a), .b(b), .in_valid(in_valid), .op(op),
    .clear(clear), .z_out(z_s), .out_valid(v_s), .overflow(o_s));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a beat sampled on cycle c lands on cycle c+3.
  typedef struct {
    logic [19:0] a;
    logic [17:0] b;
    logic [1:0]  op;
    int          due;
  } beat_t;

  beat_t       q[$];
  int          cyc = 0;
  logic [37:0] mz_u = '0, mz_s = '0;
  bit          mo_u = 1'b0, mo_s = 1'b0, mv = 1'b0;

  task automatic upd(input bit sgn, input beat_t bt, input logic [37:0] zi,
                     output logic [37:0] zo, output bit ovo);
    longint av, bv, zv, p, r, lo, hi;
    if (sgn) begin
      av = longint'($signed(bt.a));
      bv = longint'($signed(bt.b));
      zv = longint'($signed(zi));
      lo = -(64'sd1 <<< 37);
      hi = (64'sd1 <<< 37) - 1;
    end else begin
      av = longint'(bt.a);
      bv = longint'(bt.b);
      zv = longint'(zi);
      lo = 0;
      hi = (64'sd1 <<< 38) - 1;
    end
    p = av * bv;
    case (bt.op)
      ADD:     r = zv + p;
      SUB:     r = zv - p;
      LOAD:    r = p;
      default: r = -p;
    endcase
    ovo = (r < lo) || (r > hi);
    if (ovo && SAT) zo = (r < lo) ? lo[37:0] : hi[37:0];
    else            zo = r[37:0];
  endtask

  always @(posedge clk) begin
    beat_t       bt;
    logic [37:0] nz;
    bit          no;
    cyc++;
    if (reset) begin
      q.delete();
      mz_u = '0; mz_s = '0; mo_u = 1'b0; mo_s = 1'b0; mv = 1'b0;
    end else begin
      mv = 1'b0;
      if (clear) begin
        mz_u = '0; mz_s = '0; mo_u = 1'b0; mo_s = 1'b0;
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        bt = q.pop_front();
        mv = 1'b1;
        upd(1'b0, bt, mz_u, nz, no); mz_u = nz; mo_u = mo_u | no;
        upd(1'b1, bt, mz_s, nz, no); mz_s = nz; mo_s = mo_s | no;
      end
      if (in_valid) q.push_back('{a, b, op, cyc + 3});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("z_u", 64'(z_u), 64'(mz_u));
      check("ov_u", 64'(o_u), 64'(mo_u));
      check("vld_u", 64'(v_u), 64'(mv));
      check("z_s", 64'(z_s), 64'(mz_s));
      check("ov_s", 64'(o_s), 64'(mo_s));
      check("vld_s", 64'(v_s), 64'(mv));
    end
  end

  task automatic drive(input bit v, input logic [1:0] o, input logic [19:0] av,
                       input logic [17:0] bv, input bit clr, input bit rst);
    @(negedge clk);
    in_valid = v; op = o; a = av; b = bv; clear = clr; reset = rst;
  endtask

  task automatic idle();
    drive(1'b0, ADD, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic run_until(input bit sgn, output int n);
    n = 0;
    do begin
      idle();
      n++;
    end while (((sgn ? v_s : v_u) !== 1'b1) && n < 10);
  endtask

  initial begin
    int          n;
    int          beats;
    bit          seen;
    logic [37:0] e;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          beats;
    bit          seen;
    logic [37:0] e;

    drive(1'b0, ADD, '0, '0, 1'b0, 1'b1);
    drive(1'b0, ADD, '0, '0, 1'b0, 1'b1);
    idle();
    chk_en = 1'b1;
    check("reset_z", 64'(z_u), 64'd0);
    check("reset_vld", 64'(v_u), 64'd0);
    check("reset_ov", 64'(o_u), 64'd0);

    drive(1'b1, SUB, 20'h7ffff, 18'h1ffff, 1'b0, 1'b0);
    run_until(1'b0, n);
    check("latency", 64'(n), 64'd4);
    e = SAT ? 38'h0 : 38'h300009ffff;
    check("underflow_z", 64'(z_u), 64'(e));
    check("underflow_ov", 64'(o_u), 64'd1);

    drive(1'b1, LOAD, 20'd3, 18'd5, 1'b0, 1'b0);
    drive(1'b1, ADD, 20'd2, 18'd7, 1'b0, 1'b0);
    run_until(1'b0, n);
    check("b2b_first", 64'(z_u), 64'd15);
    idle();
    check("b2b_second_vld", 64'(v_u), 64'd1);
    check("b2b_second_z", 64'(z_u), 64'd29);
    check("b2b_sticky_ov", 64'(o_u), 64'd1);

    drive(1'b1, ADD, 20'd6, 18'd7, 1'b0, 1'b0);
    idle();
    idle();
    drive(1'b0, ADD, '0, '0, 1'b1, 1'b0);
    idle();
    check("clr_beat_z", 64'(z_u), 64'd42);
    check("clr_beat_ov", 64'(o_u), 64'd0);
    check("clr_beat_vld", 64'(v_u), 64'd1);

    drive(1'b0, ADD, '0, '0, 1'b1, 1'b0);
    drive(1'b1, LNEG, 20'd100, 18'd4, 1'b0, 1'b0);
    run_until(1'b1, n);
    e = -38'sd400;
    check("signed_lneg", 64'(z_s), 64'(e));
    drive(1'b1, ADD, 20'hfffff, 18'h3ffff, 1'b0, 1'b0);
    run_until(1'b1, n);
    e = -38'sd399;
    check("signed_add", 64'(z_s), 64'(e));

    drive(1'b1, ADD, 20'd9, 18'd9, 1'b0, 1'b0);
    drive(1'b1, ADD, 20'd8, 18'd8, 1'b0, 1'b0);
    drive(1'b1, SUB, 20'd7, 18'd7, 1'b0, 1'b0);
    drive(1'b0, ADD, '0, '0, 1'b0, 1'b1);
    drive(1'b0, ADD, '0, '0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (v_u === 1'b1 || v_s === 1'b1) seen = 1'b1;
    end
    check("midflight_no_vld", 64'(seen), 64'd0);
    check("midflight_z_u", 64'(z_u), 64'd0);
    check("midflight_z_s", 64'(z_s), 64'd0);

    beats = 0;
    while (beats < 600) begin
      bit          v, clr, rst;
      logic [19:0] ra;
      logic [17:0] rb;
      v   = ($urandom_range(0, 4) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1) == 0) begin
        ra = 20'($urandom);
        rb = 18'($urandom);
      end else begin
        ra = 20'($urandom_range(0, 15)) - 20'd8;
        rb = 18'($urandom_range(0, 15)) - 18'd8;
      end
      drive(v, 2'($urandom_range(0, 3)), ra, rb, clr, rst);
      if (v) beats++;
    end
    for (int i = 0; i < 6; i++) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
